// File: rtl/logic_unit_arbiter_pkg.sv
// Shared widths, opcode encodings, FSM states and the latched request record
// for the two-requester logic-unit arbiter.
package logic_unit_pkg;

  localparam int WIDTH = 32;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NAND = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             id;
  } req_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the result consumer
// and the arbiter. master = requesters + consumer side, slave = arbiter side.
interface logic_unit_arbiter_if;
  import logic_unit_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy
  );

endinterface

// File: rtl/logic_unit_arbiter_core.sv
// Purely combinational bitwise logic core; the reserved opcode yields zero
// with the error flag set.
module logic_core
  import logic_unit_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_NOTA: result_o = ~a_i;
      default: err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic core between two requesters:
// IDLE accepts one op, EXEC evaluates it, RESP holds the tagged result.
module logic_unit_arbiter
  import logic_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  lu_if
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  req_t             req_q, req_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] core_result;
  logic             core_err;

  // With both requesting, the one not served last wins; a lone requester always wins.
  always_comb begin
    grant_valid = (state_q == ST_IDLE) && (lu_if.req0_valid || lu_if.req1_valid);
    if (lu_if.req0_valid && lu_if.req1_valid) grant_id = ~last_grant_q;
    else                                      grant_id = lu_if.req1_valid;
  end

  logic_core u_core (
    .op_i     (req_q.op),
    .a_i      (req_q.a),
    .b_i      (req_q.b),
    .result_o (core_result),
    .err_o    (core_err)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          req_d.id     = grant_id;
          req_d.op     = grant_id ? lu_if.req1_op : lu_if.req0_op;
          req_d.a      = grant_id ? lu_if.req1_a  : lu_if.req0_a;
          req_d.b      = grant_id ? lu_if.req1_b  : lu_if.req0_b;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = core_result;
        rsp_zero_d  = (core_result == '0);
        rsp_err_d   = core_err;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (lu_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign lu_if.req0_ready = grant_valid && !grant_id;
  assign lu_if.req1_ready = grant_valid &&  grant_id;
  assign lu_if.rsp_valid  = rsp_valid_q;
  assign lu_if.rsp_id     = req_q.id;
  assign lu_if.rsp_data   = rsp_data_q;
  assign lu_if.rsp_zero   = rsp_zero_q;
  assign lu_if.rsp_err    = rsp_err_q;
  assign lu_if.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: hand-computed results, latency,
// round-robin order, response stall and mid-op reset.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic_unit_arbiter_if bus ();

  logic_unit_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .lu_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!bus.rsp_valid && k < 10) begin
      tick();
      k++;
    end
    check(tag, {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic set_req(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g;
    logic pend;
    int   g;
    int   r;

    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},      32'd0);
    check("rst_data",  bus.rsp_data,           32'd0);
    check("rst_id",    {31'd0, bus.rsp_id},    32'd0);
    check("rst_zero",  {31'd0, bus.rsp_zero},  32'd0);
    check("rst_err",   {31'd0, bus.rsp_err},   32'd0);
    rst = 1'b0;
    tick();

    // 1: req0 NAND of complementary operands, exact latency, latched operands
    set_req(0, OP_NAND, 32'hCA981547, 32'h3567EAB8);
    #1;
    check("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("t1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle_reqs();
    bus.req0_a = 32'h0; bus.req0_b = 32'h0; bus.req0_op = OP_OR;
    #1;
    check("t1_exec_valid",  {31'd0, bus.rsp_valid},  32'd0);
    check("t1_exec_busy",   {31'd0, bus.busy},       32'd1);
    check("t1_exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    check("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("t1_data",      bus.rsp_data,           32'hFFFFFFFF);
    check("t1_id",        {31'd0, bus.rsp_id},    32'd0);
    check("t1_zero",      {31'd0, bus.rsp_zero},  32'd0);
    check("t1_err",       {31'd0, bus.rsp_err},   32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    check("t1_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("t1_done_busy",  {31'd0, bus.busy},      32'd0);

    // 2: req1 XOR of equal operands
    set_req(1, OP_XOR, 32'h3567EAB8, 32'h3567EAB8);
    #1;
    check("t2_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("t2_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    idle_reqs();
    wait_rsp("t2_rsp_valid");
    check("t2_data", bus.rsp_data,          32'd0);
    check("t2_zero", {31'd0, bus.rsp_zero}, 32'd1);
    check("t2_id",   {31'd0, bus.rsp_id},   32'd1);
    check("t2_err",  {31'd0, bus.rsp_err},  32'd0);
    tick();
    check("t2_done_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // 3: both requesters continuously valid, grants alternate starting with req0
    set_req(0, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    set_req(1, OP_OR,  32'h0F0F0000, 32'h000000F1);
    exp_g = 1'b0; pend = 1'b0; g = 0; r = 0;
    for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
      #1;
      if (bus.rsp_valid) begin
        check("t3_rsp_id",   {31'd0, bus.rsp_id}, {31'd0, pend});
        check("t3_rsp_data", bus.rsp_data, pend ? 32'h0F0F00F1 : 32'hF000F000);
        r++;
      end
      if (bus.req0_ready || bus.req1_ready) begin
        check("t3_grant", {30'd0, bus.req1_ready, bus.req0_ready}, exp_g ? 32'd2 : 32'd1);
        pend  = exp_g;
        exp_g = ~exp_g;
        g++;
      end
      if (g < 4) tick();
    end
    tick();
    idle_reqs();
    wait_rsp("t3_last_valid");
    check("t3_last_id",   {31'd0, bus.rsp_id}, 32'd1);
    check("t3_last_data", bus.rsp_data,        32'h0F0F00F1);
    r++;
    check("t3_grants", g, 32'd4);
    check("t3_rsps",   r, 32'd4);
    tick();

    // 4: consumer stalls 5 cycles; response stable, no grants while busy
    bus.rsp_ready = 1'b0;
    set_req(0, OP_XNOR, 32'h0000FFFF, 32'h00FF00FF);
    #1;
    check("t4_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    set_req(1, OP_AND, 32'h12345678, 32'h9ABCDEF0);
    bus.req0_a = 32'hDEADBEEF;
    wait_rsp("t4_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid",  {31'd0, bus.rsp_valid},  32'd1);
      check("t4_hold_data",   bus.rsp_data,            32'hFF0000FF);
      check("t4_hold_id",     {31'd0, bus.rsp_id},     32'd0);
      check("t4_hold_busy",   {31'd0, bus.busy},       32'd1);
      check("t4_hold_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("t4_hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
      tick();
    end
    idle_reqs();
    bus.rsp_ready = 1'b1;
    tick();
    check("t4_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("t4_done_busy",  {31'd0, bus.busy},      32'd0);

    // 5: reserved opcode still answers, flagged as error
    set_req(1, OP_RSVD, 32'h1, 32'h1);
    #1;
    check("t5_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    idle_reqs();
    wait_rsp("t5_rsp_valid");
    check("t5_err",  {31'd0, bus.rsp_err},  32'd1);
    check("t5_data", bus.rsp_data,          32'd0);
    check("t5_zero", {31'd0, bus.rsp_zero}, 32'd1);
    check("t5_id",   {31'd0, bus.rsp_id},   32'd1);
    tick();
    check("t5_done_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // 6: reset during EXEC after a req0 grant; next contested grant goes to req0
    set_req(0, OP_AND, 32'hFFFFFFFF, 32'h0000FFFF);
    #1;
    check("t6_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    idle_reqs();
    check("t6_exec_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("t6_rst_busy",  {31'd0, bus.busy},      32'd0);
    check("t6_rst_err",   {31'd0, bus.rsp_err},   32'd0);
    check("t6_rst_zero",  {31'd0, bus.rsp_zero},  32'd0);
    tick();
    rst = 1'b0;
    set_req(0, OP_AND, 32'hFFFFFFFF, 32'h0000FFFF);
    set_req(1, OP_NOR, 32'h0, 32'h0);
    #1;
    check("t6_post_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("t6_post_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle_reqs();
    wait_rsp("t6_rsp_valid");
    check("t6_data", bus.rsp_data,        32'h0000FFFF);
    check("t6_id",   {31'd0, bus.rsp_id}, 32'd0);
    tick();
    check("t6_done_valid", {31'd0, bus.rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
